// File: rtl/turn_input_fsm.sv
// Turn-based button input sequencer: picks an action class, a piece/captive, then a
// destination, emitting a commit pulse and handing the turn to the other player.
module turn_input_fsm #(
    parameter int NBTN    = 4,
    parameter int IDX_W   = 4,
    parameter int TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NBTN-1:0]  btn,
    output logic [3:0]       state,
    output logic             player,
    output logic [IDX_W-1:0] sel_idx,
    output logic [IDX_W-1:0] arg_idx,
    output logic             commit,
    output logic             timeout
);

    typedef enum logic [3:0] {
        POC = 4'b0000,
        WP  = 4'b0001,
        WC  = 4'b0010,
        PD  = 4'b0101,
        CP  = 4'b0110
    } state_t;

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NBTN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST2 = IDX_W'(NBTN - 2);
    localparam logic [IDX_W-1:0] IDX_CANCEL = '0;
    localparam logic [31:0]      TO_LAST   = 32'(TIMEOUT - 1);

    state_t           cur;
    logic [NBTN-1:0]  btn_q;
    logic [NBTN-1:0]  press;
    logic             ev;
    logic [IDX_W-1:0] press_idx;
    logic [31:0]      cnt;
    logic             expire;

    assign state = cur;

    always_comb begin
        press     = btn & ~btn_q;
        // exactly one rising edge this cycle; chords are treated as noise
        ev        = (press != '0) && ((press & (press - NBTN'(1))) == '0);
        press_idx = '0;
        for (int i = 0; i < NBTN; i++) begin
            if (press[i]) press_idx = IDX_W'(i);
        end
        expire = (TIMEOUT != 0) && (cur != POC) && (cnt == TO_LAST) && !ev;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= POC;
            player  <= 1'b0;
            sel_idx <= '0;
            arg_idx <= '0;
            commit  <= 1'b0;
            timeout <= 1'b0;
            // all ones so a button held through reset is not seen as a press
            btn_q   <= '1;
            cnt     <= '0;
        end else begin
            btn_q   <= btn;
            commit  <= 1'b0;
            timeout <= 1'b0;

            if (ev)
                cnt <= '0;
            else if (cur != POC && cnt != '1)
                cnt <= cnt + 32'd1;

            case (cur)
                POC: begin
                    if (ev) begin
                        if (press_idx == IDX_LAST)
                            cur <= WP;
                        else if (press_idx == IDX_LAST2)
                            cur <= WC;
                    end
                end
                WP, WC: begin
                    if (ev) begin
                        if (press_idx == IDX_CANCEL) begin
                            cur <= POC;
                        end else begin
                            sel_idx <= press_idx;
                            cur     <= (cur == WP) ? PD : CP;
                        end
                    end else if (expire) begin
                        cur     <= POC;
                        timeout <= 1'b1;
                        cnt     <= '0;
                    end
                end
                PD, CP: begin
                    if (ev) begin
                        if (press_idx == IDX_CANCEL) begin
                            cur <= (cur == PD) ? WP : WC;
                        end else begin
                            arg_idx <= press_idx;
                            commit  <= 1'b1;
                            player  <= ~player;
                            cur     <= POC;
                        end
                    end else if (expire) begin
                        cur     <= POC;
                        timeout <= 1'b1;
                        cnt     <= '0;
                    end
                end
                default: begin
                    cur <= POC;
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turn_input_fsm.sv
// Directed bench for turn_input_fsm (NBTN=4, TIMEOUT=8): vector table plus
// hand-written hold, timeout and reset sequences.
module tb_turn_input_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic [3:0] state;
    logic       player;
    logic [3:0] sel_idx;
    logic [3:0] arg_idx;
    logic       commit;
    logic       timeout;

    int total = 0;
    int passed = 0;

    turn_input_fsm #(.NBTN(4), .IDX_W(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .btn(btn), .state(state), .player(player),
        .sel_idx(sel_idx), .arg_idx(arg_idx), .commit(commit), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] b;
        logic [3:0] st;
        logic       p;
        logic [3:0] sel;
        logic [3:0] arg;
        logic       c;
        logic       t;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] b, input logic [3:0] st, input logic p,
                       input logic [3:0] sel, input logic [3:0] arg,
                       input logic c, input logic t);
        vec_t v;
        v.b = b; v.st = st; v.p = p; v.sel = sel; v.arg = arg; v.c = c; v.t = t;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] obs();
        return {17'd0, state, player, sel_idx, arg_idx, commit, timeout};
    endfunction

    function automatic logic [31:0] pack(input logic [3:0] st, input logic p,
                                         input logic [3:0] sel, input logic [3:0] arg,
                                         input logic c, input logic t);
        return {17'd0, st, p, sel, arg, c, t};
    endfunction

    task automatic step(input logic [3:0] b);
        btn = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int entries;
        int touts;
        logic [3:0] prev;

        // move path
        add(4'b0000, 4'h0, 0, 4'd0, 4'd0, 0, 0);
        add(4'b1000, 4'h1, 0, 4'd0, 4'd0, 0, 0);
        add(4'b0000, 4'h1, 0, 4'd0, 4'd0, 0, 0);
        add(4'b0010, 4'h5, 0, 4'd1, 4'd0, 0, 0);
        add(4'b0000, 4'h5, 0, 4'd1, 4'd0, 0, 0);
        add(4'b0100, 4'h0, 1, 4'd1, 4'd2, 1, 0);
        add(4'b0000, 4'h0, 1, 4'd1, 4'd2, 0, 0);
        // captive path
        add(4'b0100, 4'h2, 1, 4'd1, 4'd2, 0, 0);
        add(4'b0000, 4'h2, 1, 4'd1, 4'd2, 0, 0);
        add(4'b1000, 4'h6, 1, 4'd3, 4'd2, 0, 0);
        add(4'b0000, 4'h6, 1, 4'd3, 4'd2, 0, 0);
        add(4'b0010, 4'h0, 0, 4'd3, 4'd1, 1, 0);
        add(4'b0000, 4'h0, 0, 4'd3, 4'd1, 0, 0);
        // cancel ladder
        add(4'b1000, 4'h1, 0, 4'd3, 4'd1, 0, 0);
        add(4'b0000, 4'h1, 0, 4'd3, 4'd1, 0, 0);
        add(4'b0010, 4'h5, 0, 4'd1, 4'd1, 0, 0);
        add(4'b0000, 4'h5, 0, 4'd1, 4'd1, 0, 0);
        add(4'b0001, 4'h1, 0, 4'd1, 4'd1, 0, 0);
        add(4'b0000, 4'h1, 0, 4'd1, 4'd1, 0, 0);
        add(4'b0001, 4'h0, 0, 4'd1, 4'd1, 0, 0);
        add(4'b0000, 4'h0, 0, 4'd1, 4'd1, 0, 0);
        add(4'b0001, 4'h0, 0, 4'd1, 4'd1, 0, 0);
        add(4'b0000, 4'h0, 0, 4'd1, 4'd1, 0, 0);
        // chords ignored in POC, WP, PD; held cancel acts once
        add(4'b1010, 4'h0, 0, 4'd1, 4'd1, 0, 0);
        add(4'b0000, 4'h0, 0, 4'd1, 4'd1, 0, 0);
        add(4'b1000, 4'h1, 0, 4'd1, 4'd1, 0, 0);
        add(4'b0000, 4'h1, 0, 4'd1, 4'd1, 0, 0);
        add(4'b1010, 4'h1, 0, 4'd1, 4'd1, 0, 0);
        add(4'b0000, 4'h1, 0, 4'd1, 4'd1, 0, 0);
        add(4'b0010, 4'h5, 0, 4'd1, 4'd1, 0, 0);
        add(4'b0000, 4'h5, 0, 4'd1, 4'd1, 0, 0);
        add(4'b1010, 4'h5, 0, 4'd1, 4'd1, 0, 0);
        add(4'b0000, 4'h5, 0, 4'd1, 4'd1, 0, 0);
        add(4'b0001, 4'h1, 0, 4'd1, 4'd1, 0, 0);
        add(4'b0001, 4'h1, 0, 4'd1, 4'd1, 0, 0);
        add(4'b0000, 4'h1, 0, 4'd1, 4'd1, 0, 0);
        add(4'b0001, 4'h0, 0, 4'd1, 4'd1, 0, 0);
        add(4'b0000, 4'h0, 0, 4'd1, 4'd1, 0, 0);

        rst = 1'b1;
        btn = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_state", obs(), pack(4'h0, 0, 4'd0, 4'd0, 0, 0));
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].b);
            chk($sformatf("vec%0d", i), obs(),
                pack(tbl[i].st, tbl[i].p, tbl[i].sel, tbl[i].arg, tbl[i].c, tbl[i].t));
        end

        // 50-cycle hold of 1000: one WP entry, then the idle timeout drops back
        entries = 0;
        touts = 0;
        prev = state;
        for (int k = 0; k < 50; k++) begin
            step(4'b1000);
            if (prev == 4'h0 && state == 4'h1) entries++;
            if (timeout) touts++;
            prev = state;
        end
        chk("hold_entries", 32'(entries), 32'd1);
        chk("hold_timeouts", 32'(touts), 32'd1);
        step(4'b0000);
        chk("hold_end", obs(), pack(4'h0, 0, 4'd1, 4'd1, 0, 0));

        // idle timeout from WP, 8 edges after entry
        step(4'b1000);
        chk("to_enter", {28'd0, state}, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            step(4'b0000);
            if (k < 8)
                chk($sformatf("to_wait%0d", k), {27'd0, state, timeout}, {27'd0, 4'h1, 1'b0});
            else
                chk("to_expire", obs(), pack(4'h0, 0, 4'd1, 4'd1, 0, 1));
        end
        step(4'b0000);
        chk("to_pulse_end", {31'd0, timeout}, 32'd0);

        // press on expiry cycle wins, then timeout out of PD
        step(4'b1000);
        for (int k = 1; k <= 7; k++) step(4'b0000);
        chk("race_pre", {28'd0, state}, 32'h1);
        step(4'b0010);
        chk("race_event", obs(), pack(4'h5, 0, 4'd1, 4'd1, 0, 0));
        for (int k = 1; k <= 8; k++) begin
            step(4'b0000);
            if (k < 8)
                chk($sformatf("pd_wait%0d", k), {27'd0, state, timeout}, {27'd0, 4'h5, 1'b0});
            else
                chk("pd_expire", obs(), pack(4'h0, 0, 4'd1, 4'd1, 0, 1));
        end

        // reset mid-selection with a button held
        step(4'b0000);
        step(4'b1000); step(4'b0000); step(4'b0010); step(4'b0000);
        step(4'b0100);
        chk("pre_rst_commit", obs(), pack(4'h0, 1, 4'd1, 4'd2, 1, 0));
        step(4'b0000);
        step(4'b1000); step(4'b0000); step(4'b0011 & 4'b0010);
        chk("pre_rst_pd", obs(), pack(4'h5, 1, 4'd1, 4'd2, 0, 0));
        btn = 4'b0100;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_reset", obs(), pack(4'h0, 0, 4'd0, 4'd0, 0, 0));
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(4'b0100);
            chk($sformatf("held_after_rst%0d", k), obs(), pack(4'h0, 0, 4'd0, 4'd0, 0, 0));
        end
        step(4'b0000);
        step(4'b0100);
        chk("repress_wc", obs(), pack(4'h2, 0, 4'd0, 4'd0, 0, 0));
        step(4'b0000);
        step(4'b0001);
        chk("wc_cancel", obs(), pack(4'h0, 0, 4'd0, 4'd0, 0, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
